// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - operand sequencer with valid/ready output stage
// Step mode emits one channel per LOAD; burst mode streams all channels from one LOAD.
module operand_loader #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 2,
   parameter int AUTO     = 0,
   localparam int IDXW    = $clog2(CHANNELS)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [3:0]                tx,
   input  logic [CHANNELS*WIDTH-1:0] in_bus,
   input  logic                      ready,
   output logic [WIDTH-1:0]          entrada,
   output logic [IDXW-1:0]           contador,
   output logic                      valid,
   output logic                      last,
   output logic                      busy
);

   localparam logic [3:0]      TX_CLEAR = 4'd0;
   localparam logic [3:0]      TX_LOAD  = 4'd1;
   localparam logic [3:0]      TX_HOLD  = 4'd2;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHANNELS - 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] entrada_q, entrada_d;
   logic [IDXW-1:0]  contador_q, contador_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             stage_free;
   logic             emit;
   logic             at_last;
   logic [WIDTH-1:0] chan_word;

   always_comb begin
      chan_word = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (contador_q == IDXW'(k)) begin
            chan_word = in_bus[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      stage_free = !valid_q || ready;
      at_last    = (contador_q == LAST_IDX);
      // In BURST anything but HOLD or CLEAR keeps the stream going.
      if (AUTO != 0) begin
         emit = stage_free &&
                (((state_q == S_IDLE) && (tx == TX_LOAD)) ||
                 ((state_q == S_BURST) && (tx != TX_HOLD) && (tx != TX_CLEAR)));
      end else begin
         emit = stage_free && (tx == TX_LOAD);
      end

      state_d    = state_q;
      entrada_d  = entrada_q;
      contador_d = contador_q;
      valid_d    = valid_q;
      last_d     = last_q;

      if (tx == TX_CLEAR) begin
         state_d    = S_IDLE;
         entrada_d  = '0;
         contador_d = '0;
         valid_d    = 1'b0;
         last_d     = 1'b0;
      end else if (emit) begin
         entrada_d  = chan_word;
         valid_d    = 1'b1;
         last_d     = at_last;
         contador_d = at_last ? '0 : contador_q + 1'b1;
         state_d    = at_last ? S_IDLE : S_BURST;
      end else if (stage_free) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         entrada_q  <= '0;
         contador_q <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         entrada_q  <= entrada_d;
         contador_q <= contador_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
      end
   end

   assign entrada  = entrada_q;
   assign contador = contador_q;
   assign valid    = valid_q;
   assign last     = last_q;
   assign busy     = (AUTO != 0) ? (state_q == S_BURST) : (contador_q != '0);

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - bench for operand_loader in step (2 ch) and burst (4 ch) modes
module tb_operand_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [3:0]  tx_s, tx_b;
   logic [7:0]  bus_s;
   logic [15:0] bus_b;
   logic        rdy_s, rdy_b;
   logic [3:0]  ent_s, ent_b;
   logic        cnt_s;
   logic [1:0]  cnt_b;
   logic        val_s, val_b, lst_s, lst_b, bsy_s, bsy_b;

   operand_loader #(.WIDTH(4), .CHANNELS(2), .AUTO(0)) u_step (
      .clock(clk), .reset(reset), .tx(tx_s), .in_bus(bus_s), .ready(rdy_s),
      .entrada(ent_s), .contador(cnt_s), .valid(val_s), .last(lst_s), .busy(bsy_s)
   );

   operand_loader #(.WIDTH(4), .CHANNELS(4), .AUTO(1)) u_burst (
      .clock(clk), .reset(reset), .tx(tx_b), .in_bus(bus_b), .ready(rdy_b),
      .entrada(ent_b), .contador(cnt_b), .valid(val_b), .last(lst_b), .busy(bsy_b)
   );

   int       tests = 0;
   int       fails = 0;
   int       m_next  [2];
   bit       m_burst [2];
   bit       m_valid [2];
   bit       m_last  [2];
   bit [3:0] m_ent   [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a word register, a "next channel" counter mod ch, and a burst-active flag.
   task automatic model(input int i, input int ch, input bit am, input logic [15:0] bus,
                        input logic [3:0] t, input logic rdy);
      bit go;
      if (reset || t == 4'd0) begin
         m_ent[i] = 0; m_valid[i] = 0; m_last[i] = 0; m_next[i] = 0; m_burst[i] = 0;
      end else if (m_valid[i] && !rdy) begin
      end else begin
         if (am) go = m_burst[i] ? (t != 4'd2) : (t == 4'd1);
         else    go = (t == 4'd1);
         if (go) begin
            m_ent[i]   = bus[m_next[i]*4 +: 4];
            m_valid[i] = 1;
            m_last[i]  = (m_next[i] == ch - 1);
            if (am) m_burst[i] = !m_last[i];
            m_next[i]  = (m_next[i] + 1) % ch;
         end else begin
            m_valid[i] = 0;
            m_last[i]  = 0;
         end
      end
   endtask

   task automatic tick();
      model(0, 2, 1'b0, {8'h00, bus_s}, tx_s, rdy_s);
      model(1, 4, 1'b1, bus_b, tx_b, rdy_b);
      @(posedge clk);
      #1;
      chk("step.entrada",  ent_s, m_ent[0]);
      chk("step.contador", cnt_s, m_next[0]);
      chk("step.valid",    val_s, m_valid[0]);
      chk("step.last",     lst_s, m_last[0]);
      chk("step.busy",     bsy_s, m_next[0] != 0);
      chk("burst.entrada", ent_b, m_ent[1]);
      chk("burst.contador", cnt_b, m_next[1]);
      chk("burst.valid",   val_b, m_valid[1]);
      chk("burst.last",    lst_b, m_last[1]);
      chk("burst.busy",    bsy_b, m_burst[1]);
   endtask

   function automatic logic [3:0] rand_tx();
      int r = $urandom_range(0, 19);
      if (r == 0) return 4'd0;
      if (r < 12) return 4'd1;
      if (r < 15) return 4'd2;
      return 4'($urandom_range(3, 15));
   endfunction

   initial begin
      // Reset held two cycles with LOAD pending
      reset = 1; tx_s = 4'd1; tx_b = 4'd1; rdy_s = 1; rdy_b = 1;
      bus_s = 8'($urandom); bus_b = 16'($urandom);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst.s_valid", val_s, 0); chk("rst.b_valid", val_b, 0);
         chk("rst.s_entrada", ent_s, 0); chk("rst.b_busy", bsy_b, 0);
      end
      reset = 0; tx_s = 4'd2; tx_b = 4'd2;
      tick();
      chk("post_rst.s_entrada", ent_s, 0); chk("post_rst.b_entrada", ent_b, 0);
      chk("post_rst.s_valid", val_s, 0); chk("post_rst.b_contador", cnt_b, 0);
      chk("post_rst.b_last", lst_b, 0); chk("post_rst.s_busy", bsy_s, 0);

      // Step mode alternation A, B, A
      bus_s = 8'hBA; tx_s = 4'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("step2.entrada", ent_s, (i == 1) ? 4'hB : 4'hA);
         chk("step2.last", lst_s, (i == 1));
         chk("step2.contador", cnt_s, (i == 1) ? 0 : 1);
         chk("step2.valid", val_s, 1);
      end

      // Stall holds the word and does not skip an index
      tx_s = 4'd0; tick();
      tx_s = 4'd1; tick();
      chk("stall.first", ent_s, 4'hA);
      rdy_s = 0; tick();
      chk("stall.entrada", ent_s, 4'hA); chk("stall.valid", val_s, 1);
      chk("stall.contador", cnt_s, 1);
      rdy_s = 1; tick();
      chk("stall.resume", ent_s, 4'hB); chk("stall.last", lst_s, 1);
      tx_s = 4'd2;

      // Burst: LOAD then HOLD pauses after word 1
      bus_b = 16'h4321; tx_b = 4'd0; tick();
      tx_b = 4'd1; tick();
      chk("burst.w1", ent_b, 4'h1); chk("burst.w1_busy", bsy_b, 1);
      tx_b = 4'd2; tick();
      chk("burst.hold_valid", val_b, 0); chk("burst.hold_busy", bsy_b, 1);
      chk("burst.hold_cnt", cnt_b, 1);
      tx_b = 4'd1; tick(); chk("burst.resume2", ent_b, 4'h2);
      tx_b = 4'd7; tick(); chk("burst.resume3", ent_b, 4'h3);
      tick();
      chk("burst.resume4", ent_b, 4'h4); chk("burst.resume4_last", lst_b, 1);
      chk("burst.resume4_busy", bsy_b, 0); chk("burst.resume4_cnt", cnt_b, 0);

      // Fresh burst: LOAD then opcode 7 streams 1..4 back-to-back
      tx_b = 4'd1;
      for (int k = 0; k < 4; k++) begin
         tick();
         tx_b = 4'd7;
         chk("burst.seq_entrada", ent_b, 4'(k + 1));
         chk("burst.seq_last", lst_b, (k == 3));
         chk("burst.seq_busy", bsy_b, (k != 3));
         chk("burst.seq_valid", val_b, 1);
      end
      tx_b = 4'd2; tick();
      chk("burst.idle_valid", val_b, 0); chk("burst.idle_busy", bsy_b, 0);

      // CLEAR under a stall mid-burst
      tx_b = 4'd1; tick();
      tx_b = 4'd7; tick(); chk("clr.w2", ent_b, 4'h2);
      rdy_b = 0; tx_b = 4'd0; tick();
      chk("clr.valid", val_b, 0); chk("clr.entrada", ent_b, 0);
      chk("clr.contador", cnt_b, 0); chk("clr.busy", bsy_b, 0);
      rdy_b = 1; tx_b = 4'd1; tick();
      chk("clr.restart", ent_b, 4'h1);
      tx_b = 4'd2; tick();

      // Unrecognised opcode in step mode behaves as HOLD
      tx_s = 4'd0; tick();
      tx_s = 4'd1; tick(); chk("unk.a", ent_s, 4'hA);
      tx_s = 4'd9; tick();
      chk("unk.valid", val_s, 0); chk("unk.contador", cnt_s, 1); chk("unk.entrada", ent_s, 4'hA);
      tx_s = 4'd1; tick();
      chk("unk.b", ent_s, 4'hB); chk("unk.last", lst_s, 1);

      // Randomised traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 63) == 0);
         tx_s  = rand_tx();
         tx_b  = rand_tx();
         rdy_s = ($urandom_range(0, 3) != 0);
         rdy_b = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) bus_s = 8'($urandom);
         if ($urandom_range(0, 7) == 0) bus_b = 16'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
